// File: rtl/tod_bcd_counter_if.sv
// Control and display bundle for the BCD time-of-day counter.
// TOD_ALARM_EN adds the alarm register write port and the alarm_hit pulse.
interface tod_bcd_counter_if;
    logic        en;
    logic        h12;
    logic        load;
    logic [23:0] load_time;
    logic [23:0] data;
    logic        pm;
    logic        sec_tick;
    logic        day_tick;
    logic        load_err;
`ifdef TOD_ALARM_EN
    logic        alarm_wr;
    logic [23:0] alarm_time;
    logic        alarm_arm;
    logic        alarm_hit;

    modport master (
        output en, h12, load, load_time, alarm_wr, alarm_time, alarm_arm,
        input  data, pm, sec_tick, day_tick, load_err, alarm_hit
    );
    modport slave (
        input  en, h12, load, load_time, alarm_wr, alarm_time, alarm_arm,
        output data, pm, sec_tick, day_tick, load_err, alarm_hit
    );
`else
    modport master (
        output en, h12, load, load_time,
        input  data, pm, sec_tick, day_tick, load_err
    );
    modport slave (
        input  en, h12, load, load_time,
        output data, pm, sec_tick, day_tick, load_err
    );
`endif
endinterface

// File: rtl/tod_bcd_counter.sv
// Prescaled hh:mm:ss BCD time-of-day counter with load check, 12/24h display and carry pulses.
// Optional alarm comparator is built when TOD_ALARM_EN is defined.
module tod_bcd_counter #(
    parameter int unsigned CLK_PER_SEC = 1,
    parameter logic [23:0] RESET_TIME  = 24'h000000
) (
    input  logic              CLK,
    input  logic              reset,
    tod_bcd_counter_if.slave  bus
);
    localparam int unsigned   PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] pcnt_reg;
    logic [23:0]   time_reg;
    logic          sec_tick_reg;
    logic          day_tick_reg;
    logic          load_err_reg;

    logic [3:0]  h_t, h_u, m_t, m_u, s_t, s_u;
    logic [7:0]  hour;
    logic [23:0] time_next;
    logic        c0, c1, c2, c3, day_wrap;
    logic        pcnt_last, adv, load_ok;
    logic [7:0]  disp_hour;

    function automatic logic valid_time(input logic [23:0] t);
        return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
               (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
               (t[19:16] <= 4'd9) && (t[23:20] <= 4'd2) &&
               ((t[23:20] != 4'd2) || (t[19:16] <= 4'd3));
    endfunction

    assign {h_t, h_u, m_t, m_u, s_t, s_u} = time_reg;
    assign hour      = time_reg[23:16];
    assign pcnt_last = (pcnt_reg == PCNT_LAST);
    assign adv       = bus.en & pcnt_last & ~bus.load;
    assign load_ok   = valid_time(bus.load_time);

    // Ripple carry through the digits; each carry requires all lower digits at their maximum.
    assign c0       = (s_u == 4'd9);
    assign c1       = c0 & (s_t == 4'd5);
    assign c2       = c1 & (m_u == 4'd9);
    assign c3       = c2 & (m_t == 4'd5);
    assign day_wrap = c3 & (hour == 8'h23);

    always_comb begin
        time_next[3:0]   = c0 ? 4'd0 : s_u + 4'd1;
        time_next[7:4]   = c1 ? 4'd0 : (c0 ? s_t + 4'd1 : s_t);
        time_next[11:8]  = c2 ? 4'd0 : (c1 ? m_u + 4'd1 : m_u);
        time_next[15:12] = c3 ? 4'd0 : (c2 ? m_t + 4'd1 : m_t);
        time_next[23:16] = hour;
        if (c3) begin
            if (hour == 8'h23)
                time_next[23:16] = 8'h00;
            else if (h_u == 4'd9)
                time_next[23:16] = {h_t + 4'd1, 4'd0};
            else
                time_next[23:16] = {h_t, h_u + 4'd1};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pcnt_reg     <= '0;
            time_reg     <= RESET_TIME;
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            sec_tick_reg <= adv;
            day_tick_reg <= adv & day_wrap;
            load_err_reg <= bus.load & ~load_ok;
            if (bus.load) begin
                if (load_ok) begin
                    time_reg <= bus.load_time;
                    pcnt_reg <= '0;
                end
            end else if (bus.en) begin
                pcnt_reg <= pcnt_last ? '0 : pcnt_reg + PW'(1);
                if (pcnt_last)
                    time_reg <= time_next;
            end
        end
    end

    // 12-hour view: 00 -> 12, 13..19 -> 01..07, 20/21 -> 08/09, 22/23 -> 10/11.
    always_comb begin
        disp_hour = hour;
        if (bus.h12) begin
            if (hour == 8'h00)
                disp_hour = 8'h12;
            else if ((h_t == 4'd1) && (h_u >= 4'd3))
                disp_hour = {4'd0, h_u - 4'd2};
            else if (h_t == 4'd2)
                disp_hour = (h_u <= 4'd1) ? {4'd0, h_u + 4'd8} : {4'd1, h_u - 4'd2};
        end
    end

    assign bus.data     = {disp_hour, time_reg[15:0]};
    assign bus.pm       = (hour >= 8'h12);
    assign bus.sec_tick = sec_tick_reg;
    assign bus.day_tick = day_tick_reg;
    assign bus.load_err = load_err_reg;

`ifdef TOD_ALARM_EN
    logic [23:0] alarm_reg;
    logic        alarm_hit_reg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            alarm_reg     <= 24'h000000;
            alarm_hit_reg <= 1'b0;
        end else begin
            alarm_hit_reg <= adv & bus.alarm_arm & (time_next == alarm_reg);
            if (bus.alarm_wr && valid_time(bus.alarm_time))
                alarm_reg <= bus.alarm_time;
        end
    end

    assign bus.alarm_hit = alarm_hit_reg;
`endif
endmodule

// File: tb/tb_tod_bcd_counter.sv
// Directed bench for tod_bcd_counter: a seconds-based reference model feeds a scoreboard queue.
// Alarm scenarios run only when TOD_ALARM_EN is defined.
module tb_tod_bcd_counter;
    localparam int          CPS    = 4;
    localparam logic [23:0] RST_TM = 24'h235958;

    typedef struct {
        string       tag;
        logic [23:0] data;
        logic        pm;
        logic        st;
        logic        dt;
        logic        le;
        logic        ah;
    } exp_t;

    logic CLK = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int   m_secs;
    int   m_pcnt;
    int   m_alarm;

    tod_bcd_counter_if bus ();

    tod_bcd_counter #(.CLK_PER_SEC(CPS), .RESET_TIME(RST_TM)) dut (
        .CLK   (CLK),
        .reset (reset_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic bit bcd_ok(input logic [23:0] t);
        int h;
        h = 10 * int'(t[23:20]) + int'(t[19:16]);
        for (int i = 0; i < 6; i++)
            if (t[4*i +: 4] > 4'd9) return 1'b0;
        return (t[15:12] <= 4'd5) && (t[7:4] <= 4'd5) && (h <= 23);
    endfunction

    function automatic int bcd_to_secs(input logic [23:0] t);
        int h, m, s;
        h = 10 * int'(t[23:20]) + int'(t[19:16]);
        m = 10 * int'(t[15:12]) + int'(t[11:8]);
        s = 10 * int'(t[7:4]) + int'(t[3:0]);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [23:0] show(input int secs, input logic h12);
        int h;
        h = secs / 3600;
        if (h12) begin
            h = h % 12;
            if (h == 0) h = 12;
        end
        return {bcd8(h), bcd8((secs / 60) % 60), bcd8(secs % 60)};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input string tag, input logic st, input logic dt,
                               input logic le, input logic ah);
        exp_t e;
        e.tag  = tag;
        e.data = show(m_secs, bus.h12);
        e.pm   = (m_secs / 3600) >= 12;
        e.st   = st;
        e.dt   = dt;
        e.le   = le;
        e.ah   = ah;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 24'd0, 24'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".data"}, bus.data, e.data);
        check({e.tag, ".pm"}, 24'(bus.pm), 24'(e.pm));
        check({e.tag, ".sec_tick"}, 24'(bus.sec_tick), 24'(e.st));
        check({e.tag, ".day_tick"}, 24'(bus.day_tick), 24'(e.dt));
        check({e.tag, ".load_err"}, 24'(bus.load_err), 24'(e.le));
`ifdef TOD_ALARM_EN
        check({e.tag, ".alarm_hit"}, 24'(bus.alarm_hit), 24'(e.ah));
`endif
        $display("[%0t] %s data=%h pm=%b st=%b dt=%b le=%b", $time, e.tag,
                 bus.data, bus.pm, bus.sec_tick, bus.day_tick, bus.load_err);
    endtask

    // Advance the model by one clock edge using the inputs currently driven, then compare.
    task automatic step(input string tag);
        logic st, dt, le, ah;
        st = 1'b0; dt = 1'b0; le = 1'b0; ah = 1'b0;
        if (bus.load) begin
            if (bcd_ok(bus.load_time)) begin
                m_secs = bcd_to_secs(bus.load_time);
                m_pcnt = 0;
            end else begin
                le = 1'b1;
            end
        end else if (bus.en) begin
            if (m_pcnt == CPS - 1) begin
                m_pcnt = 0;
                m_secs = (m_secs + 1) % 86400;
                st = 1'b1;
                dt = (m_secs == 0);
`ifdef TOD_ALARM_EN
                ah = bus.alarm_arm && (m_secs == m_alarm);
`endif
            end else begin
                m_pcnt++;
            end
        end
`ifdef TOD_ALARM_EN
        if (bus.alarm_wr && bcd_ok(bus.alarm_time))
            m_alarm = bcd_to_secs(bus.alarm_time);
`endif
        push_expect(tag, st, dt, le, ah);
        @(posedge CLK);
        #1;
        compare_front();
    endtask

    task automatic check_now(input string tag);
        push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        compare_front();
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.en        = 1'b1;
        bus.h12       = 1'b0;
        bus.load      = 1'b0;
        bus.load_time = 24'h000000;
`ifdef TOD_ALARM_EN
        bus.alarm_wr   = 1'b0;
        bus.alarm_time = 24'h000000;
        bus.alarm_arm  = 1'b0;
`endif
        m_secs  = bcd_to_secs(RST_TM);
        m_pcnt  = 0;
        m_alarm = 0;

        #12;
        check_now("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) step("run_to_midnight");

        bus.load = 1'b1; bus.load_time = 24'h126000;
        step("load_bad_minutes");
        bus.load_time = 24'h130000; bus.h12 = 1'b1;
        step("load_13h_h12");
        bus.load = 1'b0;
        step("after_load");
        bus.load = 1'b1; bus.load_time = 24'h245959;
        step("load_bad_hour");
        bus.load = 1'b0; bus.h12 = 1'b0;

        for (int i = 0; i < CPS && m_pcnt != CPS - 1; i++) step("approach_last");
        bus.load = 1'b1; bus.load_time = 24'h101010;
        step("load_on_advance_edge");
        bus.load = 1'b0;
        for (int i = 0; i < CPS + 1; i++) step("post_load_count");

        step("mid_count");
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) step("enable_low");
        bus.en = 1'b1;
        for (int i = 0; i < CPS + 2; i++) step("resume");

        bus.en = 1'b0; bus.load = 1'b1; bus.load_time = 24'h000030;
        step("load_midnight_hour");
        bus.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.h12 = 1'b1; #1; check_now("h12_on_hour00");
            bus.h12 = 1'b0; #1; check_now("h12_off_hour00");
        end
        bus.h12 = 1'b1; bus.load = 1'b1; bus.load_time = 24'h225931; bus.en = 1'b1;
        step("load_22h_h12");
        bus.load = 1'b0;
        for (int i = 0; i < CPS; i++) step("h12_pm_count");
        bus.h12 = 1'b0;

`ifdef TOD_ALARM_EN
        bus.alarm_wr = 1'b1; bus.alarm_time = 24'h000005; bus.alarm_arm = 1'b1;
        bus.load = 1'b1; bus.load_time = 24'h000003;
        step("alarm_setup");
        bus.alarm_wr = 1'b0; bus.load = 1'b0;
        for (int i = 0; i < 3 * CPS; i++) step("alarm_armed");
        bus.alarm_arm = 1'b0; bus.load = 1'b1; bus.load_time = 24'h000003;
        step("alarm_reload");
        bus.load = 1'b0;
        for (int i = 0; i < 3 * CPS; i++) step("alarm_disarmed");
        bus.alarm_arm = 1'b1; bus.alarm_wr = 1'b1; bus.alarm_time = 24'h007000;
        step("alarm_bad_write");
        bus.alarm_wr = 1'b0; bus.load = 1'b1; bus.load_time = 24'h000004;
        step("alarm_load_onto");
        bus.load = 1'b0;
        for (int i = 0; i < 2 * CPS; i++) step("alarm_after_bad_write");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tod_bcd_counter.md
Name: tod_bcd_counter

Overview:
- Parametrised time-of-day counter that keeps hh:mm:ss in packed BCD and advances once per second.
- It replaces the fixed-modulus cascaded seconds/minutes/hours counter.
- Adds: a clock prescaler, count enable, synchronous time load with validity check, 12/24-hour display mode, and second/day carry pulses.
- Sits between the board clock and the 7-segment display driver; it feeds calendar logic through the day_tick pulse.

Parameters:
- CLK_PER_SEC, 1: CLK cycles per one-second advance. 1 means every enabled cycle advances the time. Legal range 1 to 2^27.
- RESET_TIME, 24'h000000: BCD hhmmss value loaded on reset. Must be a valid 24-hour time.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; prescaler and time hold while low.
- h12  input  1  display mode: 1 = 12-hour, 0 = 24-hour. Affects the outputs only.
- load  input  1  one-cycle strobe: write load_time.
- load_time  input  24  BCD hhmmss in 24-hour format.
- data  output  24  displayed BCD time: [23:16] hours, [15:8] minutes, [7:0] seconds.
- pm  output  1  1 when the internal hour is 12..23. Valid in both modes.
- sec_tick  output  1  one-cycle pulse on every one-second advance.
- day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 advance.
- load_err  output  1  one-cycle pulse: load rejected.

Behaviour:
- Internal state:
  - Prescaler count pcnt, width clog2(CLK_PER_SEC) with a minimum of 1.
  - Six BCD digits in 24-hour form: h_t, h_u, m_t, m_u, s_t, s_u.
- Reset (reset = 0, asynchronous):
  - Time = RESET_TIME, pcnt = 0.
  - sec_tick = 0, day_tick = 0, load_err = 0.
- Advance condition, evaluated each edge:
  - adv = en & (pcnt == CLK_PER_SEC-1) & !load.
  - When en is high: pcnt wraps to 0 on reaching CLK_PER_SEC-1, otherwise increments.
  - When en is low: pcnt and the time hold.
- On adv, the time increments by one second:
  - s_u 9 -> 0 carries into s_t.
  - s_t 5 with carry -> 0 carries into m_u; minutes behave the same way.
  - Hours roll 23 -> 00.
  - Only valid BCD is ever produced; no digit exceeds 9 and no tens digit exceeds its limit.
- sec_tick and day_tick are registered. They are high the cycle after the advancing edge, i.e. coincident with the new time on data.
- Load takes priority over advance in the same cycle:
  - A valid load_time sets the time and clears pcnt to 0. No sec_tick or day_tick is produced for that cycle.
  - load_time is valid when: every nibble ≤ 9, s_t ≤ 5, m_t ≤ 5, and hours ≤ 23.
  - An invalid load leaves time and pcnt unchanged and pulses load_err the next cycle.
  - Load is accepted regardless of en.
- Display mapping is combinational from the time registers; h12 changes are visible in the same cycle.
  - h12 = 0: data equals the internal time.
  - h12 = 1: hour 00 shows as 12; 01..12 unchanged; 13..23 shows as hour-12 in BCD (e.g. 8'h17 -> 8'h05).
  - Minutes and seconds are unchanged in both modes.
- pm = (internal hour ≥ 12), independent of h12.
- Reset asserted mid-second discards the partial prescaler count. The first advance after release occurs CLK_PER_SEC enabled cycles later.

Optional Feature:
- Macro: TOD_ALARM_EN.
- Defined: adds these ports:
  - alarm_wr (input 1): one-cycle strobe writing the alarm register.
  - alarm_time (input 24): 24-hour BCD alarm time.
  - alarm_arm (input 1): level, enables the alarm.
  - alarm_hit (output 1): one-cycle pulse.
- Alarm register reset value: 24'h000000.
- An invalid alarm_time write is ignored silently.
- alarm_hit pulses, registered and coincident with sec_tick, when:
  - an advance makes the internal time equal the alarm register, and
  - alarm_arm = 1.
- Loads that land on the alarm time do not fire alarm_hit.
- Not defined: the ports, register and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with RESET_TIME = 24'h235958, CLK_PER_SEC = 4, en = 1:
  - data = 24'h235958 held for 4 cycles, then 24'h235959 with a sec_tick pulse.
  - 4 cycles later, data = 24'h000000 with sec_tick and day_tick both pulsing.
- load = 1 with load_time = 24'h126000 -> time unchanged, load_err pulses for one cycle. Then load 24'h130000 with h12 = 1 -> data = 24'h010000, pm = 1.
- load asserted on the same edge where pcnt = CLK_PER_SEC-1 -> loaded value appears, no sec_tick, next advance occurs CLK_PER_SEC cycles later.
- en = 0 for 10 cycles mid-count -> data and pcnt frozen, no ticks. Re-enable -> count resumes from the held pcnt.
- h12 toggling at internal hour 00 -> data[23:16] alternates 8'h00 / 8'h12 combinationally, pm = 0 throughout.
- TOD_ALARM_EN defined, alarm 24'h000005 armed, time loaded to 24'h000003 -> alarm_hit pulses once, coincident with data = 24'h000005.
- Same run with alarm_arm = 0 -> no alarm_hit pulse.
